// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store front-end for single_port_mem.
//
// Accepts one memory op at a time from the LSU issue logic and drives the memory's
// en/re/wr command pulses. It then waits for mem_done and returns a tagged response.
// Sub-word loads are shifted down and sign- or zero-extended. Sub-word stores are
// performed as a read-modify-write of the containing word.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   req_*_i / req_ready_o  request channel; accept = req_valid_i & req_ready_o
//   resp_*_o / resp_ready_i response channel; resp_valid_o held until resp_ready_i
//   mem_en/re/wr_o         single-cycle command pulses to single_port_mem
//   mem_addr_o             word-aligned address, stable through ISSUE and WAIT
//   mem_wdata_o            write data, stable through ISSUE and WAIT
//   mem_rdata_i            read data, valid while mem_done_i is high
//   mem_done_i             one-cycle completion pulse from memory
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TAG_WIDTH      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_store_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [TAG_WIDTH-1:0]  resp_tag_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_err_o,
  output logic                  mem_en_o,
  output logic                  mem_re_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_done_i
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrIssue,
    StWrWait,
    StResp
  } state_e;

  // Shift the addressed lane(s) down to bit 0, then extend.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    unique case (size)
      SzByte:  res = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SzHalf:  res = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the right-justified store data onto the addressed lane(s) of old.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] res;
    res = old;
    unique case (size)
      SzByte: begin
        case (off)
          2'd0:    res[7:0]   = wd[7:0];
          2'd1:    res[15:8]  = wd[7:0];
          2'd2:    res[23:16] = wd[7:0];
          default: res[31:24] = wd[7:0];
        endcase
      end
      SzHalf: begin
        if (off[1]) res[31:16] = wd[15:0];
        else        res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  state_e                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic req_illegal;
  logic timeout_hit;

  assign req_illegal = (req_size_i == 2'b11) ||
                       ((req_size_i == SzHalf) && req_addr_i[0]) ||
                       ((req_size_i == SzWord) && (req_addr_i[1:0] != 2'b00));

  // A mem_done on the final WAIT cycle is checked first, so it wins over the timeout.
  assign timeout_hit = (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          is_store_d  = req_is_store_i;
          size_d      = req_size_i;
          uns_d       = req_unsigned_i;
          off_d       = req_addr_i[1:0];
          wdata_d     = req_wdata_i;
          tag_d       = req_tag_i;
          mem_addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          if (req_illegal) begin
            resp_err_d = 1'b1;
            state_d    = StResp;
          end else if (req_is_store_i && (req_size_i == SzWord)) begin
            mem_wdata_d = req_wdata_i;
            state_d     = StWrIssue;
          end else begin
            state_d = StRdIssue;
          end
        end
      end
      StRdIssue: begin
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (mem_done_i) begin
          if (is_store_q) begin
            mem_wdata_d = store_merge(mem_rdata_i, wdata_q, size_q, off_q);
            state_d     = StWrIssue;
          end else begin
            resp_data_d = load_extract(mem_rdata_i, size_q, off_q, uns_q);
            state_d     = StResp;
          end
        end else if (timeout_hit) begin
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrIssue: begin
        cnt_d   = '0;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (mem_done_i) begin
          state_d = StResp;
        end else if (timeout_hit) begin
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Handshake and command outputs are flops decoded from the next state, so each
    // one mirrors the state register exactly and can never glitch.
    req_ready_d  = (state_d == StIdle);
    resp_valid_d = (state_d == StResp);
    mem_re_d     = (state_d == StRdIssue);
    mem_wr_d     = (state_d == StWrIssue);
    mem_en_d     = mem_re_d | mem_wr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      tag_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      mem_en_q     <= mem_en_d;
      mem_re_q     <= mem_re_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_tag_o   = tag_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign mem_en_o     = mem_en_q;
  assign mem_re_o     = mem_re_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a table of ops with hand-computed results run
// against a small word memory with programmable latency, followed by hand-written
// sequences for reset-while-waiting and a stray mem_done.
module tb_lsu_mem_ctrl;

  localparam int unsigned AW  = 20;
  localparam int unsigned TW  = 6;
  localparam int unsigned TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_is_store_i = 1'b0;
  logic [1:0]    req_size_i = 2'b00;
  logic          req_unsigned_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [31:0]   req_wdata_i = '0;
  logic [TW-1:0] req_tag_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic [TW-1:0] resp_tag_o;
  logic [31:0]   resp_data_o;
  logic          resp_err_o;
  logic          mem_en_o, mem_re_o, mem_wr_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;
  logic          mem_done_i;

  lsu_mem_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_store_i(req_is_store_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_tag_o(resp_tag_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_en_o(mem_en_o), .mem_re_o(mem_re_o), .mem_wr_o(mem_wr_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_done_i(mem_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: 16 words, mem_done arrives lat cycles after the issue pulse.
  bit [31:0] mem [16];
  int        lat = 1;
  bit        withhold = 1'b0;
  logic      spur_done = 1'b0;
  logic      mdl_done;
  logic [31:0] mdl_rdata;
  int        mdl_cnt;
  logic      op_wr;
  logic [3:0] op_idx;
  logic [31:0] op_wdata;
  int        rd_cnt = 0, wr_cnt = 0, en_cnt = 0;

  assign mem_done_i  = mdl_done | spur_done;
  assign mem_rdata_i = mdl_rdata;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdl_cnt   <= 0;
      mdl_done  <= 1'b0;
      mdl_rdata <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (mem_en_o) begin
        en_cnt   <= en_cnt + 1;
        if (mem_re_o) rd_cnt <= rd_cnt + 1;
        if (mem_wr_o) wr_cnt <= wr_cnt + 1;
        op_wr    <= mem_wr_o;
        op_idx   <= mem_addr_o[5:2];
        op_wdata <= mem_wdata_o;
        if (!withhold) begin
          if (lat <= 1) begin
            mdl_done <= 1'b1;
            if (mem_wr_o) mem[mem_addr_o[5:2]] <= mem_wdata_o;
            else          mdl_rdata <= mem[mem_addr_o[5:2]];
          end else begin
            mdl_cnt <= lat - 1;
          end
        end
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) begin
          mdl_done <= 1'b1;
          if (op_wr) mem[op_idx] <= op_wdata;
          else       mdl_rdata <= mem[op_idx];
        end
      end
    end
  end

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [19:0] addr;
    logic [31:0] wd;
    logic [5:0]  tag;
    int          lat;
    bit          wh;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_rd;
    int          exp_wr;
    int          exp_cyc;  // posedges from accept to resp_valid; -1 = not checked
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [1:0] sz, input logic uns,
                     input logic [19:0] addr, input logic [31:0] wd, input logic [5:0] tag,
                     input int l, input bit wh, input int hold,
                     input logic [31:0] ed, input logic ee, input int erd, input int ewr,
                     input int ecyc);
    vec_t v;
    v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.tag = tag;
    v.lat = l; v.wh = wh; v.hold = hold;
    v.exp_data = ed; v.exp_err = ee; v.exp_rd = erd; v.exp_wr = ewr; v.exp_cyc = ecyc;
    vecs.push_back(v);
  endtask

  task automatic do_op(input string nm, input vec_t v);
    int rd0, wr0, en0, cyc;
    bit stable;
    logic [31:0] d0;
    logic [5:0]  t0;
    logic        e0;
    rd0 = rd_cnt; wr0 = wr_cnt; en0 = en_cnt;
    lat = v.lat; withhold = v.wh;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_is_store_i = v.st; req_size_i = v.sz; req_unsigned_i = v.uns;
    req_addr_i = v.addr; req_wdata_i = v.wd; req_tag_i = v.tag;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    cyc = 0;
    while (!resp_valid_o && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    if (!resp_valid_o) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_noresp: got no resp_valid, want one within 200 cycles", nm);
      withhold = 1'b0;
      return;
    end
    chk({nm, "_data"}, resp_data_o, v.exp_data);
    chk({nm, "_err"}, 32'(resp_err_o), 32'(v.exp_err));
    chk({nm, "_tag"}, 32'(resp_tag_o), 32'(v.tag));
    if (v.exp_cyc >= 0) chk({nm, "_latency"}, cyc, v.exp_cyc);
    if (v.hold > 0) begin
      stable = 1'b1;
      d0 = resp_data_o; t0 = resp_tag_o; e0 = resp_err_o;
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk_i); #1;
        if (!resp_valid_o || req_ready_o || resp_data_o !== d0 || resp_tag_o !== t0 ||
            resp_err_o !== e0) stable = 1'b0;
      end
      chk({nm, "_stall_stable"}, 32'(stable), 32'd1);
    end
    @(negedge clk_i);
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    chk({nm, "_handshake"}, {30'b0, resp_valid_o, req_ready_o}, 32'b01);
    chk({nm, "_reads"}, rd_cnt - rd0, v.exp_rd);
    chk({nm, "_writes"}, wr_cnt - wr0, v.exp_wr);
    chk({nm, "_en_pulses"}, en_cnt - en0, v.exp_rd + v.exp_wr);
    withhold = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  v;
    bit    quiet;

    //  st  sz     uns  addr     wdata         tag lat wh hold exp_data     err rd wr cyc
    add(1, 2'b10, 0, 20'h4, 32'h0000_0007, 1,  1, 0, 0, 32'h0,        0, 0, 1, 2);
    add(0, 2'b10, 0, 20'h4, 32'h0,         2,  2, 0, 0, 32'h7,        0, 1, 0, 3);
    add(1, 2'b10, 0, 20'h8, 32'h80FF_1234, 3,  3, 0, 0, 32'h0,        0, 0, 1, 4);
    add(0, 2'b00, 0, 20'hB, 32'h0,         4,  1, 0, 0, 32'hFFFF_FF80, 0, 1, 0, 2);
    add(0, 2'b00, 1, 20'hB, 32'h0,         5,  2, 0, 0, 32'h0000_0080, 0, 1, 0, 3);
    add(0, 2'b01, 0, 20'hA, 32'h0,         6,  1, 0, 0, 32'hFFFF_80FF, 0, 1, 0, 2);
    add(0, 2'b01, 1, 20'h8, 32'h0,         7,  1, 0, 0, 32'h0000_1234, 0, 1, 0, 2);
    add(0, 2'b00, 0, 20'h9, 32'h0,         8,  1, 0, 0, 32'h0000_0012, 0, 1, 0, 2);
    add(0, 2'b01, 0, 20'h8, 32'h0,         9,  1, 0, 0, 32'h0000_1234, 0, 1, 0, 2);
    add(1, 2'b00, 0, 20'h9, 32'h0000_00AA, 10, 2, 0, 0, 32'h0,        0, 1, 1, -1);
    add(0, 2'b10, 0, 20'h8, 32'h0,         11, 1, 0, 5, 32'h80FF_AA34, 0, 1, 0, 2);
    add(1, 2'b01, 0, 20'hE, 32'h1234_BEEF, 12, 3, 0, 0, 32'h0,        0, 1, 1, -1);
    add(0, 2'b10, 0, 20'hC, 32'h0,         13, 1, 0, 0, 32'hBEEF_0000, 0, 1, 0, 2);
    add(0, 2'b00, 0, 20'hE, 32'h0,         14, 1, 0, 0, 32'hFFFF_FFEF, 0, 1, 0, 2);
    add(0, 2'b01, 1, 20'hE, 32'h0,         15, 1, 0, 0, 32'h0000_BEEF, 0, 1, 0, 2);
    add(0, 2'b10, 0, 20'h6, 32'h0,         16, 1, 0, 0, 32'h0,        1, 0, 0, 0);
    add(0, 2'b01, 0, 20'h3, 32'h0,         17, 1, 0, 0, 32'h0,        1, 0, 0, 0);
    add(0, 2'b11, 0, 20'h0, 32'h0,         18, 1, 0, 0, 32'h0,        1, 0, 0, 0);
    add(1, 2'b01, 0, 20'h1, 32'hFFFF_FFFF, 19, 1, 0, 0, 32'h0,        1, 0, 0, 0);
    add(1, 2'b10, 0, 20'h2, 32'hFFFF_FFFF, 20, 1, 0, 0, 32'h0,        1, 0, 0, 0);
    add(0, 2'b10, 0, 20'h4, 32'h0,         21, 1, 1, 0, 32'h0,        1, 1, 0, TMO + 1);
    add(1, 2'b00, 0, 20'h0, 32'h0000_0055, 22, 1, 0, 0, 32'h0,        0, 1, 1, -1);
    add(0, 2'b00, 1, 20'h0, 32'h0,         23, 2, 0, 0, 32'h0000_0055, 0, 1, 0, 3);
    add(0, 2'b00, 0, 20'h3, 32'h0,         24, 1, 0, 0, 32'h0,        0, 1, 0, 2);
    add(1, 2'b01, 0, 20'h6, 32'h0000_8001, 25, 2, 0, 0, 32'h0,        0, 1, 1, -1);
    add(0, 2'b10, 0, 20'h4, 32'h0,         26, 1, 0, 0, 32'h8001_0007, 0, 1, 0, 2);
    add(0, 2'b01, 0, 20'h6, 32'h0,         27, 3, 0, 0, 32'hFFFF_8001, 0, 1, 0, 4);

    // Reset state, sampled while reset is still asserted.
    #12;
    chk("rst_outputs", {26'b0, req_ready_o, resp_valid_o, resp_err_o, mem_en_o, mem_re_o,
                        mem_wr_o}, 32'b10_0000);
    chk("rst_resp_data", resp_data_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_ready", {30'b0, req_ready_o, mem_en_o}, 32'b10);

    for (int i = 0; i < vecs.size(); i++) do_op($sformatf("v%0d", i), vecs[i]);

    // Stray mem_done while idle must be ignored.
    @(negedge clk_i);
    spur_done = 1'b1;
    @(negedge clk_i);
    spur_done = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (resp_valid_o || !req_ready_o || mem_en_o) quiet = 1'b0;
    end
    chk("stray_done_ignored", 32'(quiet), 32'd1);

    // Reset while waiting on a read: op is dropped, no response appears.
    withhold = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_is_store_i = 1'b0; req_size_i = 2'b10; req_addr_i = 20'h8;
    req_tag_i = 6'd40;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("mid_op_busy", {30'b0, req_ready_o, resp_valid_o}, 32'b00);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("mid_op_rst_async", {29'b0, req_ready_o, resp_valid_o, mem_en_o}, 32'b100);
    @(negedge clk_i);
    rst_ni = 1'b1;
    withhold = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      if (resp_valid_o || !req_ready_o) quiet = 1'b0;
    end
    chk("mid_op_rst_no_resp", 32'(quiet), 32'd1);

    // Normal operation resumes after the reset.
    v = vecs[10];
    v.hold = 0;
    v.tag = 6'd41;
    do_op("after_rst", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
